// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions: Q-format defaults, lane-slice macro and the
// saturation helper used by the requantiser, MAC and adder-tree blocks.
`ifndef FXP_PKG_SV
`define FXP_PKG_SV

// Select lane idx (width w) out of a flat multi-lane bus.
`define FXP_LANE(bus, idx, w) bus[(idx)*(w) +: (w)]

package fxp_pkg;

  localparam int FXP_LANES    = 4;
  localparam int FXP_IN_W     = 32;
  localparam int FXP_IN_FRAC  = 22;
  localparam int FXP_OUT_W    = 16;
  localparam int FXP_OUT_FRAC = 11;
  localparam int FXP_CNT_W    = 16;

  // Working width for the helper; any lane intermediate must fit in it.
  localparam int FXP_WIDE_W = 64;

  // Clip a wide signed value into the signed range of an out_w-bit word.
  // A caller detects clipping by comparing the result with the input.
  function automatic logic signed [FXP_WIDE_W-1:0] sat_to_width(
    input logic signed [FXP_WIDE_W-1:0] t,
    input int                           out_w
  );
    logic signed [FXP_WIDE_W-1:0] max_v;
    logic signed [FXP_WIDE_W-1:0] min_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (t > max_v)      return max_v;
    else if (t < min_v) return min_v;
    else                return t;
  endfunction

endpackage

`endif

// File: rtl/fxp_lane_requant.sv
// Combinational requantisation of one lane: optional rounding, arithmetic
// shift by IN_FRAC-OUT_FRAC (floor), then saturation to OUT_W bits.
// Rounding (add half an output LSB before the shift) is built when
// REQUANT_ROUND_EN is defined; otherwise the shift truncates toward -inf.
module fxp_lane_requant
  import fxp_pkg::*;
#(
  parameter int IN_W     = FXP_IN_W,
  parameter int IN_FRAC  = FXP_IN_FRAC,
  parameter int OUT_W    = FXP_OUT_W,
  parameter int OUT_FRAC = FXP_OUT_FRAC
) (
  input  logic [IN_W-1:0]  in_word,
  output logic [OUT_W-1:0] out_word,
  output logic             out_sat
);

  localparam int SH    = IN_FRAC - OUT_FRAC;
  localparam int EXT_W = IN_W + 1;

  if (SH < 0) begin : g_bad_frac
    $error("fxp_lane_requant: IN_FRAC must be >= OUT_FRAC");
  end
  if (EXT_W >= FXP_WIDE_W) begin : g_bad_width
    $error("fxp_lane_requant: IN_W too wide for the saturation helper");
  end

  logic signed [EXT_W-1:0]      ext;
  logic signed [EXT_W-1:0]      biased;
  logic signed [EXT_W-1:0]      shifted;
  logic signed [FXP_WIDE_W-1:0] wide;
  logic signed [FXP_WIDE_W-1:0] clipped;

  // One guard bit so the rounding add can never wrap.
  assign ext = {in_word[IN_W-1], in_word};

`ifdef REQUANT_ROUND_EN
  if (SH > 0) begin : g_round
    localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (SH - 1);
    assign biased = ext + HALF;
  end else begin : g_no_round
    assign biased = ext;
  end
`else
  assign biased = ext;
`endif

  assign shifted  = biased >>> SH;
  assign wide     = {{(FXP_WIDE_W - EXT_W){shifted[EXT_W-1]}}, shifted};
  assign clipped  = sat_to_width(wide, OUT_W);
  assign out_sat  = (clipped != wide);
  assign out_word = clipped[OUT_W-1:0];

endmodule

// File: rtl/fixed_point_requant_pipe.sv
// Multi-lane streaming requantiser: S1 registers the accumulator beat, the
// lane converters scale/round/saturate it, S2 registers the narrow result.
// Valid/ready on both sides, no skid buffer; sat_count tallies beats with
// at least one clipped lane. REQUANT_ROUND_EN selects round-half-up.
module fixed_point_requant_pipe
  import fxp_pkg::*;
#(
  parameter int LANES    = FXP_LANES,
  parameter int IN_W     = FXP_IN_W,
  parameter int IN_FRAC  = FXP_IN_FRAC,
  parameter int OUT_W    = FXP_OUT_W,
  parameter int OUT_FRAC = FXP_OUT_FRAC,
  parameter int CNT_W    = FXP_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  input  logic                   sat_clr,
  output logic [CNT_W-1:0]       sat_count
);

  logic                   s1_valid;
  logic                   s2_valid;
  logic [LANES*IN_W-1:0]  s1_data;
  logic [LANES*OUT_W-1:0] lane_word;
  logic [LANES-1:0]       lane_sat;
  logic                   in_fire;
  logic                   s1_move;
  logic                   out_fire;

  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = s2_valid && out_ready;
  assign s1_move   = s1_valid && (!s2_valid || out_ready);
  assign out_valid = s2_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fxp_lane_requant #(
      .IN_W     (IN_W),
      .IN_FRAC  (IN_FRAC),
      .OUT_W    (OUT_W),
      .OUT_FRAC (OUT_FRAC)
    ) u_lane (
      .in_word  (`FXP_LANE(s1_data, i, IN_W)),
      .out_word (`FXP_LANE(lane_word, i, OUT_W)),
      .out_sat  (lane_sat[i])
    );
  end

  // Stage 1: capture an accepted beat, empty when it moves on to stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: register the saturated lanes; hold them while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_sat  <= '0;
    end else if (s1_move) begin
      s2_valid <= 1'b1;
      out_data <= lane_word;
      out_sat  <= lane_sat;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  // Saturating tally of clipped beats entering stage 2; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (s1_move && (|lane_sat) && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fixed_point_requant_pipe.sv
// Scoreboard bench for fixed_point_requant_pipe (4 lanes, Q9.22 -> Q4.11,
// 4-bit counter). Expected beats come from an arithmetic reference model;
// a negedge monitor checks handshake, stall stability and output order.
module tb_fixed_point_requant_pipe;

  localparam int LANES = 4;
  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int CNT_W = 4;
  localparam longint SCALE   = 2048;
  localparam longint HALF    = 1024;
  localparam int     CNT_MAX = 15;

  typedef struct {
    logic [LANES*OUT_W-1:0] data;
    logic [LANES-1:0]       sat;
  } exp_t;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic [LANES-1:0]       out_sat;
  logic                   sat_clr;
  logic [CNT_W-1:0]       sat_count;

  int   n_checks;
  int   n_errors;
  int   model_cnt;
  int   ready_mode;
  exp_t exp_q[$];
  exp_t mon_e;
  logic held_valid;
  logic [LANES*OUT_W-1:0] held_data;
  logic [LANES-1:0]       held_sat;

  fixed_point_requant_pipe #(
    .LANES(LANES), .IN_W(IN_W), .IN_FRAC(22), .OUT_W(OUT_W), .OUT_FRAC(11), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: value / 2^11 rounded toward -inf (after +half if rounding), then clip.
  function automatic logic [16:0] ref_lane(input logic [31:0] w);
    longint v;
    longint t;
    logic [16:0] r;
    v = longint'($signed(w));
`ifdef REQUANT_ROUND_EN
    v = v + HALF;
`endif
    t = v / SCALE;
    if (v < 0 && (v % SCALE) != 0) t = t - 1;
    if (t > 32767)       r = {1'b1, 16'h7FFF};
    else if (t < -32768) r = {1'b1, 16'h8000};
    else                 r = {1'b0, t[15:0]};
    return r;
  endfunction

  function automatic exp_t ref_beat(input logic [LANES*IN_W-1:0] beat);
    exp_t e;
    logic [16:0] r;
    for (int i = 0; i < LANES; i++) begin
      r = ref_lane(beat[i*IN_W +: IN_W]);
      e.data[i*OUT_W +: OUT_W] = r[15:0];
      e.sat[i] = r[16];
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_lane();
    logic [31:0] tmp;
    logic [31:0] r;
    tmp = $urandom();
    case ($urandom_range(0, 3))
      0:       r = {{6{tmp[31]}}, tmp[25:0]};
      1:       r = {{5{tmp[31]}}, tmp[26:0]};
      2:       r = {{21{tmp[31]}}, tmp[10:0]};
      default: r = tmp;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // One beat: present it, wait (bounded) for acceptance, then drop valid.
  task automatic applyStimulus(input logic [LANES*IN_W-1:0] beat);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = beat;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard      = 0;
    ready_mode = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("drain_left", 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic measure_latency(input logic [LANES*IN_W-1:0] beat);
    int lat;
    in_valid = 1'b1;
    in_data  = beat;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    checkOutput("latency", 128'(lat), 128'd2);
    @(posedge clk);
    #1;
  endtask

  // Downstream readiness pattern, updated just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: handshake rule, stall stability, in-order comparison, and push.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_valid = 1'b0;
    end else begin
      checkOutput("in_ready", 128'(in_ready), 128'(!(exp_q.size() >= 2 && !out_ready)));
      if (held_valid) begin
        checkOutput("stall_valid", 128'(out_valid), 128'd1);
        checkOutput("stall_data", 128'(out_data), 128'(held_data));
        checkOutput("stall_sat", 128'(out_sat), 128'(held_sat));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL unexpected_beat: got %0h, required no beat", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("out_data", 128'(out_data), 128'(mon_e.data));
          checkOutput("out_sat", 128'(out_sat), 128'(mon_e.sat));
        end
      end
      held_valid = out_valid && !out_ready;
      held_data  = out_data;
      held_sat   = out_sat;
      if (in_valid && in_ready) begin
        mon_e = ref_beat(in_data);
        exp_q.push_back(mon_e);
        if (|mon_e.sat) model_cnt = (model_cnt < CNT_MAX) ? model_cnt + 1 : CNT_MAX;
      end
    end
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    model_cnt  = 0;
    ready_mode = 0;
    held_valid = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    sat_clr    = 1'b0;
    #1;
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_out_data", 128'(out_data), 128'd0);
    checkOutput("rst_out_sat", 128'(out_sat), 128'd0);
    checkOutput("rst_sat_count", 128'(sat_count), 128'd0);
    checkOutput("rst_in_ready", 128'(in_ready), 128'd1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unit values (+1.0 / -1.0) and latency with an empty pipe.
    measure_latency({32'h0040_0000, 32'hFFC0_0000, 32'h0040_0000, 32'hFFC0_0000});
    drain();
    checkOutput("cnt_no_sat", 128'(sat_count), 128'(model_cnt));

    // Clipping boundaries and rounding edge cases.
    applyStimulus({32'h0400_0000, 32'hFBC0_0000, 32'hFC00_0000, 32'h0040_0000});
    applyStimulus({32'h0000_0400, 32'hFFFF_FC00, 32'h03FF_FFFF, 32'hFC00_0000});
    applyStimulus({32'h7FFF_FFFF, 32'h8000_0000, 32'h03FF_F800, 32'hFBFF_FFFF});
    drain();
    checkOutput("cnt_directed", 128'(sat_count), 128'(model_cnt));

    // Randomised traffic with random backpressure.
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr   = 1'b0;
    model_cnt = 0;
    checkOutput("cnt_cleared", 128'(sat_count), 128'd0);
    ready_mode = 1;
    for (int b = 0; b < 150; b++) begin
      applyStimulus({rand_lane(), rand_lane(), rand_lane(), rand_lane()});
    end
    drain();
    checkOutput("cnt_random", 128'(sat_count), 128'(model_cnt));

    // Counter sticks at its maximum, then clear beats a same-cycle increment.
    for (int b = 0; b < 20; b++) begin
      applyStimulus({4{32'h7FFF_FFFF}});
    end
    drain();
    checkOutput("cnt_stuck", 128'(sat_count), 128'(model_cnt));
    applyStimulus({4{32'h8000_0000}});
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr   = 1'b0;
    model_cnt = 0;
    checkOutput("cnt_clr_priority", 128'(sat_count), 128'd0);
    drain();
    checkOutput("cnt_after_clr", 128'(sat_count), 128'(model_cnt));

    // Asynchronous reset with two beats held in the pipe.
    ready_mode = 2;
    @(posedge clk);
    #1;
    applyStimulus({4{32'h7FFF_FFFF}});
    applyStimulus({4{32'h0040_0000}});
    checkOutput("pre_rst_valid", 128'(out_valid), 128'd1);
    checkOutput("pre_rst_cnt", 128'(sat_count), 128'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    #1;
    checkOutput("async_rst_valid", 128'(out_valid), 128'd0);
    checkOutput("async_rst_cnt", 128'(sat_count), 128'd0);
    ready_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    measure_latency({32'h0040_0000, 32'hFFC0_0000, 32'h0400_0000, 32'hFBC0_0000});
    drain();
    checkOutput("cnt_post_rst", 128'(sat_count), 128'(model_cnt));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
